// File: rtl/counter_reg_sched.sv
// Round-robin scheduler granting one shared counter register to NREQ requesters for timed runs.
// Optional abort/aborted ports are enabled by defining CNT_ABORT_EN.
module counter_reg_sched #(
    parameter int NREQ = 2,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
`ifdef CNT_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic [NREQ-1:0]   grant,
    output logic              load_w,
    output logic [W-1:0]      q,
    output logic [NREQ-1:0]   done,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    limit;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;
    logic [NREQ-1:0] one;

    assign one = {{(NREQ-1){1'b0}}, 1'b1};

    // Scan requesters starting at rr_ptr, wrapping around; first one asserting req wins.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(rr_ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            load_w  <= 1'b0;
            q       <= '0;
            done    <= '0;
            busy    <= 1'b0;
            limit   <= '0;
            rr_ptr  <= '0;
            win_idx <= '0;
`ifdef CNT_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= one << pick;
                        win_idx <= pick;
                        limit   <= len[pick*W +: W];
                        q       <= '0;
                        load_w  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    load_w <= 1'b0;
`ifdef CNT_ABORT_EN
                    if (abort) begin
                        done    <= grant;
                        aborted <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= RUN;
                    end
`else
                    state <= RUN;
`endif
                end
                RUN: begin
`ifdef CNT_ABORT_EN
                    if (abort) begin
                        done    <= grant;
                        aborted <= 1'b1;
                        state   <= DONE;
                    end else
`endif
                    if (q == limit) begin
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        q <= q + 1'b1;
                    end
                end
                DONE: begin
                    grant  <= '0;
                    done   <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                    state  <= IDLE;
`ifdef CNT_ABORT_EN
                    aborted <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
